offset_gen_pipe: RTL and testbench

- Multi-lane, pipelined successor to the single-lane offset generator in the PE.
- Each lane's input is normalised by leading-one detection. The block emits the per-lane additive offset for the selected unary op (log: (p-FRA_BW)*ln2; gemm/div/exp: 0), plus the shift amount and error flags.
- The offset LUT is runtime-programmable and resets to analytically correct values.
- Sits between the PE operand stage and the accumulator, with valid/ready flow control on both sides.

---
 rtl/offset_gen_pipe.sv | 100 ++++++++++
 tb/tb_offset_gen_pipe.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/offset_gen_pipe.sv
// offset_gen_pipe: two-stage, multi-lane leading-one normaliser with a programmable log-offset LUT
// and valid/ready flow control on both sides.
module offset_gen_pipe #(
   parameter int LANES  = 4,
   parameter int MUL_BW = 16,
   parameter int ACC_BW = 32,
   parameter int FRA_BW = 10,
   parameter int LN2_Q  = 710,
   parameter int SW     = $clog2(MUL_BW)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [1:0]              mode_i,
   input  logic [LANES*MUL_BW-1:0] x_i,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANES*ACC_BW-1:0] offset_o,
   output logic [LANES*SW-1:0]     shift_o,
   output logic [LANES*2-1:0]      err_o,
   input  logic                    cfg_we,
   input  logic [SW-1:0]           cfg_addr,
   input  logic [ACC_BW-1:0]       cfg_wdata
);

   logic                          en;
   logic [LANES-1:0][MUL_BW-1:0]  x;
   logic [LANES-1:0][SW-1:0]      p_c, s1_p, sh_c;
   logic [LANES-1:0]              s1_zero, s1_neg;
   logic                          s1_valid;
   logic [1:0]                    s1_mode;
   logic [LANES-1:0][ACC_BW-1:0]  off_c;
   logic [LANES-1:0][1:0]         err_c;
   logic [ACC_BW-1:0]             lut [MUL_BW];

   assign x        = x_i;
   assign en       = ~out_valid | out_ready;
   assign in_ready = en;

   // Sign bit excluded: p is the magnitude position of a non-negative operand.
   always_comb begin
      p_c = '0;
      for (int l = 0; l < LANES; l++)
         for (int b = 0; b < MUL_BW - 1; b++)
            if (x[l][b]) p_c[l] = SW'(b);
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_mode  <= '0;
         s1_p     <= '0;
         s1_zero  <= '0;
         s1_neg   <= '0;
      end else if (en) begin
         s1_valid <= in_valid;
         s1_mode  <= mode_i;
         s1_p     <= p_c;
         for (int l = 0; l < LANES; l++) begin
            s1_zero[l] <= x[l] == '0;
            s1_neg[l]  <= x[l][MUL_BW-1];
         end
      end

   // LUT defaults to (k - FRA_BW) * ln2 in the input's fixed-point scale.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int k = 0; k < MUL_BW; k++)
            lut[k] <= ACC_BW'((k - FRA_BW) * LN2_Q);
      end else if (cfg_we && int'(cfg_addr) < MUL_BW) begin
         lut[cfg_addr] <= cfg_wdata;
      end

   always_comb begin
      off_c = '0;
      err_c = '0;
      sh_c  = s1_p;
      if (s1_mode == 2'b11)
         for (int l = 0; l < LANES; l++) begin
            off_c[l] = s1_zero[l] ? {1'b1, {(ACC_BW-1){1'b0}}} : s1_neg[l] ? '0 : lut[s1_p[l]];
            err_c[l] = {s1_neg[l], s1_zero[l]};
            sh_c[l]  = (s1_zero[l] | s1_neg[l]) ? '0 : s1_p[l];
         end
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         out_valid <= 1'b0;
         offset_o  <= '0;
         shift_o   <= '0;
         err_o     <= '0;
      end else if (en) begin
         out_valid <= s1_valid;
         offset_o  <= off_c;
         shift_o   <= sh_c;
         err_o     <= err_c;
      end

endmodule

// File: tb/tb_offset_gen_pipe.sv
// tb_offset_gen_pipe: directed test of offset_gen_pipe with hand-computed expectations.
module tb_offset_gen_pipe;

   logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1, cfg_we = 1'b0;
   logic         in_ready, out_valid;
   logic [1:0]   mode = '0;
   logic [63:0]  x = '0;
   logic [127:0] offset;
   logic [15:0]  shift;
   logic [7:0]   err;
   logic [3:0]   cfg_addr = '0;
   logic [31:0]  cfg_wdata = '0;
   int           n_checks = 0, n_fail = 0;
   int           sent, rcvd;
   logic         acc;

   always #5 clk = ~clk;

   offset_gen_pipe dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .mode_i(mode), .x_i(x),
      .out_valid(out_valid), .out_ready(out_ready), .offset_o(offset), .shift_o(shift), .err_o(err),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_lane(input string tag, input int l, input logic [31:0] off,
                             input logic [3:0] sh, input logic [1:0] er);
      check($sformatf("%s_l%0d_off", tag, l), offset[l*32 +: 32], off);
      check($sformatf("%s_l%0d_sh", tag, l), shift[l*4 +: 4], sh);
      check($sformatf("%s_l%0d_err", tag, l), err[l*2 +: 2], er);
   endtask

   task automatic beat(input logic [1:0] m, input logic [63:0] xv);
      mode = m;
      x = xv;
      in_valid = 1'b1;
      step;
      in_valid = 1'b0;
      step;
      check("beat_valid", out_valid, 1);
   endtask

   localparam logic [63:0] XE = {16'h0800, 16'h0400, 16'hFC00, 16'h0000};

   initial begin
      step;
      check("rst_valid", out_valid, 0);
      check("rst_offset", offset, 0);
      check("rst_shift", shift, 0);
      check("rst_err", err, 0);
      check("rst_in_ready", in_ready, 1);
      rst_n = 1'b1;
      step;

      beat(2'b11, {16'h0800, 16'h0001, 16'h4000, 16'h0400});
      check_lane("log", 0, 32'd0, 4'd10, 2'b00);
      check_lane("log", 1, 32'd2840, 4'd14, 2'b00);
      check_lane("log", 2, 32'hFFFFE444, 4'd0, 2'b00);
      check_lane("log", 3, 32'd710, 4'd11, 2'b00);

      beat(2'b11, XE);
      check_lane("elog", 0, 32'h80000000, 4'd0, 2'b01);
      check_lane("elog", 1, 32'd0, 4'd0, 2'b10);
      check_lane("elog", 2, 32'd0, 4'd10, 2'b00);
      check_lane("elog", 3, 32'd710, 4'd11, 2'b00);
      for (int m = 0; m < 3; m++) begin
         beat(2'(m), XE);
         check_lane($sformatf("em%0d", m), 0, 32'd0, 4'd0, 2'b00);
         check_lane($sformatf("em%0d", m), 1, 32'd0, 4'd14, 2'b00);
         check_lane($sformatf("em%0d", m), 2, 32'd0, 4'd10, 2'b00);
         check_lane($sformatf("em%0d", m), 3, 32'd0, 4'd11, 2'b00);
      end

      x = {4{16'h0800}};
      for (int i = 0; i < 6; i++) begin
         in_valid = i < 4;
         mode = (i % 2) ? 2'b00 : 2'b11;
         step;
         if (i >= 1 && i <= 4) begin
            check("mix_valid", out_valid, 1);
            check("mix_off", offset[31:0], ((i - 1) % 2) ? 32'd0 : 32'd710);
         end
      end
      in_valid = 1'b0;

      sent = 0;
      rcvd = 0;
      for (int c = 0; c < 40 && rcvd < 8; c++) begin
         out_ready = !(c >= 5 && c < 8);
         in_valid = sent < 8;
         mode = 2'b00;
         x = {48'h0, 16'(1 << sent)};
         #1;
         if (out_valid) begin
            check("bp_order", shift[3:0], rcvd[3:0]);
            if (out_ready) rcvd++;
            else check("bp_in_ready", in_ready, 0);
         end
         acc = in_valid && in_ready;
         @(posedge clk);
         #1;
         if (acc) sent++;
      end
      check("bp_count", rcvd, 8);
      in_valid = 1'b0;
      out_ready = 1'b1;
      step;
      step;
      check("bp_drained", out_valid, 0);

      mode = 2'b11;
      x = {48'h0, 16'h0400};
      in_valid = 1'b1;
      step;
      in_valid = 1'b0;
      cfg_we = 1'b1;
      cfg_addr = 4'd10;
      cfg_wdata = 32'h1234;
      step;
      cfg_we = 1'b0;
      check("lut_same_valid", out_valid, 1);
      check("lut_same_old", offset[31:0], 32'd0);
      beat(2'b11, {48'h0, 16'h0400});
      check("lut_new", offset[31:0], 32'h1234);
      cfg_we = 1'b1;
      cfg_addr = 4'd3;
      cfg_wdata = 32'h55;
      step;
      cfg_we = 1'b0;
      beat(2'b11, {32'h0, 16'h0008, 16'h0400});
      check("lut_keep10", offset[31:0], 32'h1234);
      check("lut_new3", offset[63:32], 32'h55);

      mode = 2'b11;
      x = {32'h0, 16'h0008, 16'h0400};
      in_valid = 1'b1;
      step;
      step;
      in_valid = 1'b0;
      check("ar_pre_valid", out_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      check("ar_valid", out_valid, 0);
      check("ar_offset", offset, 0);
      #1 rst_n = 1'b1;
      step;
      check("ar_flush1", out_valid, 0);
      step;
      check("ar_flush2", out_valid, 0);
      beat(2'b11, {32'h0, 16'h0008, 16'h0400});
      check("ar_lut10", offset[31:0], 32'd0);
      check("ar_lut3", offset[63:32], 32'hFFFFEC96);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
